// File: rtl/regfile_scoreboard_pkg.sv
// Shared constants for the register file / scoreboard slice.
// Writeback port indices, the read-port count upper bound and the number
// of writeback ports. Imported by the top and the read-port sub-module.
package regfile_scoreboard_pkg;

    localparam int unsigned WB_ALU    = 0;  // writeback port 0: ALU
    localparam int unsigned WB_LSU    = 1;  // writeback port 1: LSU, wins on collision
    localparam int unsigned NR_WB     = 2;
    localparam int unsigned NR_RD_MAX = 4;

endpackage

// File: rtl/regfile_scoreboard_if.sv
// Pipeline-side bus of the register file.
//   raddr/rdata/rready : NR_RD packed read ports, port i at [i*W +: W]
//   wen/waddr/wdata    : two writeback ports (0 = ALU, 1 = LSU)
//   issue_valid/issue_rd/issue_ready : destination reservation
//   flush              : clear all pending bits
//   busy_cnt           : registered count of pending registers
// master = pipeline (issue/writeback), slave = register file.
interface regfile_scoreboard_if #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32,
    parameter int NR_RD      = 2
);
    logic [NR_RD*ADDR_WIDTH-1:0] raddr;
    logic [NR_RD*DATA_WIDTH-1:0] rdata;
    logic [NR_RD-1:0]            rready;
    logic [1:0]                  wen;
    logic [2*ADDR_WIDTH-1:0]     waddr;
    logic [2*DATA_WIDTH-1:0]     wdata;
    logic                        issue_valid;
    logic [ADDR_WIDTH-1:0]       issue_rd;
    logic                        issue_ready;
    logic                        flush;
    logic [ADDR_WIDTH:0]         busy_cnt;

    modport master (
        output raddr, wen, waddr, wdata, issue_valid, issue_rd, flush,
        input  rdata, rready, issue_ready, busy_cnt
    );
    modport slave (
        input  raddr, wen, waddr, wdata, issue_valid, issue_rd, flush,
        output rdata, rready, issue_ready, busy_cnt
    );
endinterface

// File: rtl/regfile_scoreboard_rf_read_port.sv
// rf_read_port: one combinational operand read port.
//   raddr        : register index
//   rf, pend     : array contents and pending vector from the top
//   wact/wa/wd   : active (nonzero, enabled) writebacks this cycle
//   rdata/rready : operand value and availability
// Optional macro RF_BYPASS_EN: same-cycle write-to-read forwarding.
module rf_read_port
    import regfile_scoreboard_pkg::*;
#(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32,
    localparam int DEPTH     = 1 << ADDR_WIDTH
) (
    input  logic [ADDR_WIDTH-1:0]                raddr,
    input  logic [DEPTH-1:0][DATA_WIDTH-1:0]     rf,
    input  logic [DEPTH-1:0]                     pend,
    input  logic [NR_WB-1:0]                     wact,
    input  logic [NR_WB-1:0][ADDR_WIDTH-1:0]     wa,
    input  logic [NR_WB-1:0][DATA_WIDTH-1:0]     wd,
    output logic [DATA_WIDTH-1:0]                rdata,
    output logic                                 rready
);

`ifndef RF_BYPASS_EN
    logic unused_bypass;
    assign unused_bypass = ^{wact, wa, wd};
`endif

    always_comb begin
        rdata  = rf[raddr];
        rready = !pend[raddr];
`ifdef RF_BYPASS_EN
        // LSU checked last so it overrides ALU on a dual write
        if (wact[WB_ALU] && wa[WB_ALU] == raddr) begin
            rdata  = wd[WB_ALU];
            rready = 1'b1;
        end
        if (wact[WB_LSU] && wa[WB_LSU] == raddr) begin
            rdata  = wd[WB_LSU];
            rready = 1'b1;
        end
`endif
        if (raddr == '0) begin
            rdata  = '0;
            rready = 1'b1;
        end
    end

endmodule

// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard: multi-port integer register file with per-register
// pending scoreboard (set on issue, clear on writeback, flush clears all).
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : regfile_scoreboard_if.slave (read ports, writebacks,
//                issue reservation, flush, busy_cnt)
// x0 reads zero and is never pending. Optional macro RF_BYPASS_EN enables
// zero-cycle forwarding in the read ports.
module regfile_scoreboard
    import regfile_scoreboard_pkg::*;
#(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32,
    parameter int NR_RD      = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    regfile_scoreboard_if.slave bus
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    logic [DEPTH-1:0][DATA_WIDTH-1:0] rf;
    logic [DEPTH-1:0]                 pend, pend_nxt;
    logic [NR_WB-1:0][ADDR_WIDTH-1:0] wa;
    logic [NR_WB-1:0][DATA_WIDTH-1:0] wd;
    logic [NR_WB-1:0]                 wact;
    logic                             wb_hit_rd;
    logic                             issue_set;
    logic [ADDR_WIDTH:0]              busy_nxt;

    assign wa = bus.waddr;
    assign wd = bus.wdata;

    always_comb begin
        wact      = '0;
        wb_hit_rd = 1'b0;
        for (int k = 0; k < NR_WB; k++) begin
            wact[k] = bus.wen[k] && (wa[k] != '0);
            if (wact[k] && wa[k] == bus.issue_rd) wb_hit_rd = 1'b1;
        end
    end

    // A writeback to the requested rd in this cycle frees it, so the issue may proceed
    assign bus.issue_ready = bus.issue_valid &&
                             ((bus.issue_rd == '0) || !pend[bus.issue_rd] || wb_hit_rd);
    assign issue_set = bus.issue_ready && (bus.issue_rd != '0) && !bus.flush;

    // Clear on writeback first, then set on issue so the set wins
    always_comb begin
        pend_nxt = pend;
        if (bus.flush) begin
            pend_nxt = '0;
        end else begin
            for (int k = 0; k < NR_WB; k++)
                if (wact[k]) pend_nxt[wa[k]] = 1'b0;
            if (issue_set) pend_nxt[bus.issue_rd] = 1'b1;
        end
        pend_nxt[0] = 1'b0;
    end

    always_comb begin
        busy_nxt = '0;
        for (int i = 0; i < DEPTH; i++)
            busy_nxt = busy_nxt + {{ADDR_WIDTH{1'b0}}, pend_nxt[i]};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend         <= '0;
            bus.busy_cnt <= '0;
        end else begin
            pend         <= pend_nxt;
            bus.busy_cnt <= busy_nxt;
        end
    end

    // Port order gives LSU priority: its assignment lands last
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rf <= '0;
        end else begin
            for (int k = 0; k < NR_WB; k++)
                if (wact[k]) rf[wa[k]] <= wd[k];
        end
    end

    for (genvar i = 0; i < NR_RD; i++) begin : g_rd
        rf_read_port #(
            .ADDR_WIDTH (ADDR_WIDTH),
            .DATA_WIDTH (DATA_WIDTH)
        ) u_rd (
            .raddr  (bus.raddr[i*ADDR_WIDTH +: ADDR_WIDTH]),
            .rf     (rf),
            .pend   (pend),
            .wact   (wact),
            .wa     (wa),
            .wd     (wd),
            .rdata  (bus.rdata[i*DATA_WIDTH +: DATA_WIDTH]),
            .rready (bus.rready[i])
        );
    end

endmodule
